// File: rtl/alu_if.sv
// ALU operand/control/result bundle between the datapath registers and the ALU.
interface alu_if #(
  parameter int unsigned WIDTH = 8
);
  logic             en;
  logic             op;
  logic [WIDTH-1:0] reg_a_in;
  logic [WIDTH-1:0] reg_b_in;
  logic             carry_out;
  logic [WIDTH-1:0] res_out;

  // Datapath side: supplies operands and control, consumes registered result.
  modport master (
    output en, op, reg_a_in, reg_b_in,
    input  carry_out, res_out
  );

  // ALU side.
  modport slave (
    input  en, op, reg_a_in, reg_b_in,
    output carry_out, res_out
  );
endinterface

// File: rtl/alu.sv
// 8-bit registered add/subtract unit. SUB is A + ~B + 1, so carry_out is the
// not-borrow flag (1 when A >= B unsigned). Results wrap modulo 2^WIDTH.
module alu #(
  parameter int unsigned WIDTH = 8
) (
  input  logic  clk,
  input  logic  rst_n,
  alu_if.slave  bus
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] res_q;
  logic             carry_q;

  // Full-width sum with the carry in bit WIDTH; op doubles as the +1 for SUB.
  always_comb begin
    b_eff = bus.op ? ~bus.reg_b_in : bus.reg_b_in;
    sum   = {1'b0, bus.reg_a_in} + {1'b0, b_eff} + {{WIDTH{1'b0}}, bus.op};
  end

  // Output registers: cleared asynchronously, loaded only on enabled edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q   <= '0;
      carry_q <= 1'b0;
    end else if (bus.en) begin
      res_q   <= sum[WIDTH-1:0];
      carry_q <= sum[WIDTH];
    end
  end

  assign bus.res_out   = res_q;
  assign bus.carry_out = carry_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vector table, hold / async-reset
// sequences and random vectors, all checked through an expected-value queue.
module tb_alu;

  logic clk = 1'b0;
  logic rst_n;

  alu_if #(.WIDTH(8)) bus ();

  alu #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       c;
  } vec_t;

  vec_t       tbl [12];
  logic [8:0] sb [$];
  int         n_vec  = 0;
  int         n_miss = 0;
  logic [7:0] m_res  = 8'h00;
  logic       m_c    = 1'b0;

  task automatic check(input string name, input logic [7:0] res, input logic c,
                       input logic [7:0] exp_res, input logic exp_c);
    n_vec++;
    if (res !== exp_res || c !== exp_c) begin
      n_miss++;
      $display("FAIL %s: got res=%h carry=%b, expected res=%h carry=%b",
               name, res, c, exp_res, exp_c);
    end
  endtask

  // Reference arithmetic written in integer terms, independent of the RTL form.
  function automatic logic [8:0] model(input logic e, input logic o,
                                       input logic [7:0] a, input logic [7:0] b);
    int s;
    if (!e) return {m_c, m_res};
    if (!o) begin
      s = int'(a) + int'(b);
      return {(s > 255), 8'(s % 256)};
    end
    s = int'(a) - int'(b);
    if (s < 0) return {1'b0, 8'(s + 256)};
    return {1'b1, 8'(s)};
  endfunction

  // Drive one cycle, queue its expectation, then pop and compare after the edge.
  task automatic apply(input string name, input logic e, input logic o,
                       input logic [7:0] a, input logic [7:0] b, input logic [8:0] expv);
    logic [8:0] got;
    @(negedge clk);
    bus.en = e; bus.op = o; bus.reg_a_in = a; bus.reg_b_in = b;
    sb.push_back(expv);
    {m_c, m_res} = expv;
    @(posedge clk);
    #1;
    got = sb.pop_front();
    check(name, bus.res_out, bus.carry_out, got[7:0], got[8]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic e, o;
    logic [7:0] a, b;

    tbl[0]  = '{1'b1, 1'b1, 8'hFF, 8'h01, 8'hFE, 1'b1};
    tbl[1]  = '{1'b1, 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1};
    tbl[2]  = '{1'b1, 1'b0, 8'h12, 8'h34, 8'h46, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 8'h03, 8'h05, 8'hFE, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 8'h7A, 8'h7A, 8'h00, 1'b1};
    tbl[5]  = '{1'b1, 1'b0, 8'h80, 8'h80, 8'h00, 1'b1};
    tbl[6]  = '{1'b1, 1'b0, 8'hFF, 8'hFF, 8'hFE, 1'b1};
    tbl[7]  = '{1'b1, 1'b1, 8'h00, 8'h01, 8'hFF, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 8'h55, 8'hAA, 8'hFF, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 8'h01, 8'h02, 8'hFF, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 8'h80, 8'h7F, 8'h01, 1'b1};

    // Reset held with an enabled, non-trivial operation pending.
    rst_n = 1'b0;
    bus.en = 1'b1; bus.op = 1'b1; bus.reg_a_in = 8'hFF; bus.reg_b_in = 8'h01;
    #1;
    check("reset_initial", bus.res_out, bus.carry_out, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("reset_hold_edge", bus.res_out, bus.carry_out, 8'h00, 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_res = 8'h00; m_c = 1'b0;

    // Directed table.
    for (int i = 0; i < 12; i++)
      apply($sformatf("table_%0d", i), tbl[i].en, tbl[i].op, tbl[i].a, tbl[i].b,
            {tbl[i].c, tbl[i].res});

    // Hold: capture FE/1, then en=0 with changed op/A for 5 cycles, then enable.
    apply("hold_capture", 1'b1, 1'b1, 8'hFF, 8'h01, 9'h1FE);
    for (int i = 0; i < 5; i++)
      apply("hold_idle", 1'b0, 1'b0, 8'h10, 8'h01, 9'h1FE);
    apply("hold_release", 1'b1, 1'b0, 8'h10, 8'h01, 9'h011);

    // Async reset between edges while outputs are nonzero.
    apply("pre_async", 1'b1, 1'b1, 8'hFF, 8'h01, 9'h1FE);
    @(negedge clk);
    bus.en = 1'b1; bus.op = 1'b0; bus.reg_a_in = 8'hC0; bus.reg_b_in = 8'h50;
    #2 rst_n = 1'b0;
    #1;
    check("async_clear", bus.res_out, bus.carry_out, 8'h00, 1'b0);
    @(posedge clk); #1;
    check("async_held_edge", bus.res_out, bus.carry_out, 8'h00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    m_res = 8'h00; m_c = 1'b0;
    apply("post_async_add", 1'b1, 1'b0, 8'h12, 8'h34, 9'h046);

    // Random vectors against the integer model.
    for (int i = 0; i < 40; i++) begin
      e = ($urandom_range(0, 3) != 0);
      o = 1'($urandom_range(0, 1));
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      apply($sformatf("rand_%0d", i), e, o, a, b, model(e, o, a, b));
    end

    if (sb.size() != 0) begin
      n_vec++; n_miss++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
